// File: rtl/sweep_pkg.sv
// rtl/sweep_pkg.sv - shared types and sizes for the truth-table sweep controller
package sweep_pkg;

    localparam int NUM_VECTORS = 16;
    localparam int IDX_W       = 4;
    localparam int CNT_W       = 5;
    localparam int TMR_W       = 8;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DRIVE  = 2'd1,
        ST_SAMPLE = 2'd2,
        ST_DONE   = 2'd3
    } sweep_state_e;

endpackage

// File: rtl/sweep_if.sv
// rtl/sweep_if.sv - settle timer control link between the sweep FSM and its timer
interface sweep_if;

    logic load;
    logic enable;
    logic expire;

    // FSM side: restarts and advances the timer, watches for expiry
    modport master (output load, output enable, input expire);
    // Timer side
    modport slave  (input load, input enable, output expire);

endinterface

// File: rtl/sweep_settle_timer.sv
// rtl/sweep_settle_timer.sv - counts the cycles a vector is held before sampling
module sweep_settle_timer
    import sweep_pkg::*;
#(
    parameter int SETTLE_CYCLES = 2
) (
    input  logic    clk,
    input  logic    rst_n,
    sweep_if.slave  tmr
);

    // Expiry fires on the last enabled cycle so the FSM spends exactly
    // SETTLE_CYCLES cycles in DRIVE before moving on.
    localparam logic [TMR_W-1:0] LAST = TMR_W'(SETTLE_CYCLES - 1);

    logic [TMR_W-1:0] cnt_q;
    logic [TMR_W-1:0] cnt_d;

    // Next count: load restarts from zero, enable advances
    always_comb begin
        cnt_d = cnt_q;
        if (tmr.load) begin
            cnt_d = '0;
        end else if (tmr.enable) begin
            cnt_d = cnt_q + TMR_W'(1);
        end
    end

    // Counter register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tmr.expire = tmr.enable && (cnt_q == LAST);

endmodule

// File: rtl/circuit_sweep_ctrl.sv
// rtl/circuit_sweep_ctrl.sv - drives all 16 input vectors of a 4-input circuit and grades f
module circuit_sweep_ctrl
    import sweep_pkg::*;
#(
    parameter int SETTLE_CYCLES = 2
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   start,
    input  logic [NUM_VECTORS-1:0] expected,
    input  logic                   f,
    output logic                   x,
    output logic                   y,
    output logic                   w,
    output logic                   z,
    output logic                   busy,
    output logic                   done,
    output logic [NUM_VECTORS-1:0] tbl,
    output logic [CNT_W-1:0]       mismatch_cnt,
    output logic [IDX_W-1:0]       first_err_idx,
    output logic                   err_valid,
    output logic                   pass
);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_VECTORS - 1);

    sweep_state_e           state_q,  state_d;
    logic [IDX_W-1:0]       idx_q,    idx_d;
    logic [NUM_VECTORS-1:0] exp_q,    exp_d;
    logic [NUM_VECTORS-1:0] tbl_q,    tbl_d;
    logic [CNT_W-1:0]       mcnt_q,   mcnt_d;
    logic [IDX_W-1:0]       ferr_q,   ferr_d;
    logic                   errv_q,   errv_d;
    logic                   pass_q,   pass_d;

    sweep_if tmr_if ();

    sweep_settle_timer #(
        .SETTLE_CYCLES (SETTLE_CYCLES)
    ) u_timer (
        .clk   (clk),
        .rst_n (rst_n),
        .tmr   (tmr_if.slave)
    );

    // Next-state and datapath updates; pass is resolved on the last sample
    // so it is already valid during the DONE cycle and then simply held.
    always_comb begin
        state_d        = state_q;
        idx_d          = idx_q;
        exp_d          = exp_q;
        tbl_d          = tbl_q;
        mcnt_d         = mcnt_q;
        ferr_d         = ferr_q;
        errv_d         = errv_q;
        pass_d         = pass_q;
        tmr_if.load    = 1'b0;
        tmr_if.enable  = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    exp_d       = expected;
                    tbl_d       = '0;
                    mcnt_d      = '0;
                    ferr_d      = '0;
                    errv_d      = 1'b0;
                    pass_d      = 1'b0;
                    idx_d       = '0;
                    tmr_if.load = 1'b1;
                    state_d     = ST_DRIVE;
                end
            end
            ST_DRIVE: begin
                tmr_if.enable = 1'b1;
                if (tmr_if.expire) begin
                    state_d = ST_SAMPLE;
                end
            end
            ST_SAMPLE: begin
                tbl_d[idx_q] = f;
                if (f != exp_q[idx_q]) begin
                    mcnt_d = mcnt_q + CNT_W'(1);
                    if (!errv_q) begin
                        ferr_d = idx_q;
                        errv_d = 1'b1;
                    end
                end
                if (idx_q == LAST_IDX) begin
                    pass_d  = (mcnt_d == '0);
                    state_d = ST_DONE;
                end else begin
                    idx_d       = idx_q + IDX_W'(1);
                    tmr_if.load = 1'b1;
                    state_d     = ST_DRIVE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and result registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            idx_q   <= '0;
            exp_q   <= '0;
            tbl_q   <= '0;
            mcnt_q  <= '0;
            ferr_q  <= '0;
            errv_q  <= 1'b0;
            pass_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            exp_q   <= exp_d;
            tbl_q   <= tbl_d;
            mcnt_q  <= mcnt_d;
            ferr_q  <= ferr_d;
            errv_q  <= errv_d;
            pass_q  <= pass_d;
        end
    end

    // The circuit inputs park at vector 0 whenever no sweep is running
    assign {x, y, w, z}  = (state_q == ST_IDLE) ? '0 : idx_q;
    assign busy          = (state_q != ST_IDLE);
    assign done          = (state_q == ST_DONE);
    assign tbl           = tbl_q;
    assign mismatch_cnt  = mcnt_q;
    assign first_err_idx = ferr_q;
    assign err_valid     = errv_q;
    assign pass          = pass_q;

endmodule
